// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with a one-byte holding register, an irr/ack
// handshake towards the CPU and sticky overrun / framing-error status.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       irr,
  input  logic       ack,
  output logic       overrun,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rx_meta_q, rx_sync_q;
  logic          ack_q;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          irr_q, irr_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_s;
  logic          ack_rise_s;
  logic          stop_done_s;

  assign rx_s       = rx_sync_q;
  assign ack_rise_s = ack & ~ack_q;

  // Input conditioning: two-flop synchroniser on rx and ack edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      ack_q     <= ack;
    end
  end

  // FSM state register together with its bit counters and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  // Next-state logic; the start bit is re-checked at mid-bit to reject glitches.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          if (!rx_s) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d            = '0;
          shreg_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        // Leaving mid stop bit lets a back-to-back start edge be caught.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  assign stop_done_s = (state_q == S_STOP) && (cnt_q == CNT_LAST);

  // Output logic: deliver, overrun, framing error and acknowledge handling.
  always_comb begin
    rx_data_d   = rx_data_q;
    irr_d       = irr_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (stop_done_s && rx_s) begin
      if (!irr_q || ack_rise_s) begin
        rx_data_d = shreg_q;
        irr_d     = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (stop_done_s && !rx_s) begin
      frame_err_d = 1'b1;
      if (ack_rise_s) begin
        irr_d = 1'b0;
      end else begin
        irr_d = irr_q;
      end
    end else if (ack_rise_s) begin
      irr_d = 1'b0;
    end else begin
      irr_d = irr_q;
    end
  end

  // Registered CPU-facing outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_q   <= 8'h00;
      irr_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      irr_q       <= irr_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign irr       = irr_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx; expectations come from a
// frame-level model of the receive register, handshake and sticky flags.
module tb_uart_rx;

  localparam int C = 8;
  localparam int EXP_LAT = 9 * C + C / 2 + 3;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       irr;
  logic       ack;
  logic       overrun;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int rise_cyc;

  logic [7:0] m_data;
  logic       m_irr;
  logic       m_ovr;
  logic       m_fe;
  logic       m_ack;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .irr(irr),
    .ack(ack), .overrun(overrun), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rx_data"}, {24'h0, rx_data}, {24'h0, m_data});
    chk({tag, ".irr"}, {31'h0, irr}, {31'h0, m_irr});
    chk({tag, ".overrun"}, {31'h0, overrun}, {31'h0, m_ovr});
    chk({tag, ".frame_err"}, {31'h0, frame_err}, {31'h0, m_fe});
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_irr  = 1'b0;
    m_ovr  = 1'b0;
    m_fe   = 1'b0;
  endtask

  // Frame-level receive rules: good frame fills the holding register or overruns.
  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) begin
      m_fe = 1'b1;
    end else if (!m_irr) begin
      m_data = b;
      m_irr  = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic set_ack(input logic v);
    if (v && !m_ack) m_irr = 1'b0;
    m_ack = v;
    ack   = v;
    cycle(1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    logic       was;
    bits     = {stop_bit, b, 1'b0};
    was      = irr;
    rise_cyc = -1;
    for (int c = 0; c < 10 * C; c++) begin
      rx = bits[c / C];
      @(posedge clk);
      #1;
      if (rise_cyc < 0 && !was && irr) rise_cyc = c + 1;
    end
    rx = 1'b1;
    model_frame(b, stop_bit);
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;
    reset = 1'b1;
    rx    = 1'b1;
    ack   = 1'b0;
    m_ack = 1'b0;
    model_reset();
    cycle(3);
    chk_all("reset");
    reset = 1'b0;
    cycle(5);

    // 1: single frame, latency and hold until ack
    send_frame(8'hA5, 1'b1);
    chk("t1.latency_ok", {31'h0, (rise_cyc >= EXP_LAT - 1 && rise_cyc <= EXP_LAT + 1)}, 32'h1);
    chk_all("t1.rx");
    cycle(10);
    chk_all("t1.hold");
    set_ack(1'b1);
    chk_all("t1.acked");

    // 2: ack held high across the next frame does not clear it
    cycle(4);
    send_frame(8'h3C, 1'b1);
    cycle(2);
    chk_all("t2.rx");
    cycle(20);
    chk_all("t2.held_ack");
    set_ack(1'b0);

    // 3: two back-to-back frames without ack produce overrun
    set_ack(1'b1);
    set_ack(1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    cycle(2);
    chk_all("t3.overrun");
    set_ack(1'b1);
    chk_all("t3.acked");
    set_ack(1'b0);

    // 4: framing error with line held low, then recovery
    send_frame(8'h5A, 1'b0);
    rx = 1'b0;
    cycle(20);
    chk_all("t4.frame_err");
    rx = 1'b1;
    cycle(2 * C);
    send_frame(8'h7E, 1'b1);
    cycle(2);
    chk_all("t4.recover");

    // 5: short glitch after reset is rejected
    reset = 1'b1;
    model_reset();
    cycle(1);
    reset = 1'b0;
    cycle(3);
    rx = 1'b0;
    cycle(2);
    rx = 1'b1;
    cycle(20);
    chk_all("t5.glitch");
    send_frame(8'h96, 1'b1);
    cycle(2);
    chk_all("t5.after");

    // 6: reset during bit 4 aborts the frame
    for (int c = 0; c < 5 * C + 3; c++) begin
      rx = 1'b0;
      cycle(1);
    end
    reset = 1'b1;
    rx    = 1'b1;
    model_reset();
    cycle(1);
    chk_all("t6.reset");
    reset = 1'b0;
    cycle(2 * C);
    send_frame(8'hC3, 1'b1);
    cycle(2);
    chk_all("t6.rx");

    // Randomized frames, stop bits, gaps and acks against the model
    for (int i = 0; i < 16; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok);
      if (!ok) cycle(2 * C);
      else cycle($urandom_range(0, C));
      chk_all("rand.frame");
      if ($urandom_range(0, 1) == 1) begin
        set_ack(1'b1);
        set_ack(1'b0);
        chk_all("rand.ack");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
